// File: rtl/controller_sequencer.sv
// -----------------------------------------------------------------------------
// controller_sequencer
//
// Control unit of the 8-bit bus machine. It combines a one-hot T-state ring
// counter (T1..T6) with an opcode decoder. From these it produces the bus
// load/enable strobes for the PC, MAR, RAM, instruction register,
// accumulator, B register and output register. It also owns the halt flag.
//
// Ports:
//   clk      in   system clock; all state updates on the rising edge
//   clear    in   synchronous active-high reset; overrides everything
//   opcode   in   [3:0] instruction register opcode, meaningful in T4-T6
//   cp       out  program counter increment
//   ep       out  program counter drives bus
//   n_lm     out  MAR load (active-low)
//   n_ce     out  RAM drives bus (active-low)
//   n_li     out  instruction register load (active-low)
//   n_ei     out  instruction register operand drives bus (active-low)
//   n_la     out  accumulator load (active-low)
//   ea       out  accumulator drives bus
//   su       out  ALU subtract select
//   eu       out  ALU drives bus
//   n_lb     out  B register load (active-low)
//   n_lo     out  output register load (active-low)
//   t_state  out  [5:0] one-hot ring state, bit0 = T1
//   hlt      out  machine halted
//
// Build option:
//   SKIP_NOP_EN  When defined, an instruction returns to T1 right after its
//                last active state. LDA ends after T5, OUT after T4, and an
//                unknown opcode after T3. When undefined, every instruction
//                takes exactly six states.
// -----------------------------------------------------------------------------
module controller_sequencer (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       n_lm,
  output logic       n_ce,
  output logic       n_li,
  output logic       n_ei,
  output logic       n_la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       n_lb,
  output logic       n_lo,
  output logic [5:0] t_state,
  output logic       hlt
);

  localparam logic [3:0] LDA_OP = 4'h0;
  localparam logic [3:0] ADD_OP = 4'h1;
  localparam logic [3:0] SUB_OP = 4'h2;
  localparam logic [3:0] OUT_OP = 4'hE;
  localparam logic [3:0] HLT_OP = 4'hF;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  logic [5:0] ring_q;
  logic [5:0] ring_d;
  logic       halted_q;
  logic       halted_d;
  logic       last_state_s;

  // True when exactly one bit of the ring is set.
  function automatic logic is_onehot(input logic [5:0] v);
    is_onehot = (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

  // Detect the final active state of the current instruction (early return).
  always_comb begin
    last_state_s = 1'b0;
    case (opcode)
      LDA_OP:  last_state_s = ring_q[4];
      OUT_OP:  last_state_s = ring_q[3];
      ADD_OP:  last_state_s = 1'b0;
      SUB_OP:  last_state_s = 1'b0;
      HLT_OP:  last_state_s = 1'b0;
      default: last_state_s = ring_q[2];
    endcase
  end

  // Next-state logic for the ring counter and the halt flag.
  always_comb begin
    ring_d   = ring_q;
    halted_d = halted_q;
    if (halted_q) begin
      // The ring stays frozen at T5 until clear.
      ring_d   = ring_q;
      halted_d = 1'b1;
    end else if (!is_onehot(ring_q)) begin
      // A corrupted ring is pulled back to a known fetch state.
      ring_d   = T1;
      halted_d = 1'b0;
    end else begin
`ifdef SKIP_NOP_EN
      if (last_state_s) begin
        ring_d = T1;
      end else begin
        ring_d = {ring_q[4:0], ring_q[5]};
      end
`else
      ring_d = {ring_q[4:0], ring_q[5]};
`endif
      // HLT is decoded in T4. The ring still steps to T5 and then freezes there.
      if (ring_q[3] && (opcode == HLT_OP)) begin
        halted_d = 1'b1;
      end else begin
        halted_d = 1'b0;
      end
    end
  end

  // State registers; clear has priority over advancing and over halt.
  always_ff @(posedge clk) begin
    if (clear) begin
      ring_q   <= T1;
      halted_q <= 1'b0;
    end else begin
      ring_q   <= ring_d;
      halted_q <= halted_d;
    end
  end

  // Strobe decode from the ring, the halt flag and the opcode.
  always_comb begin
    cp   = 1'b0;
    ep   = 1'b0;
    n_lm = 1'b1;
    n_ce = 1'b1;
    n_li = 1'b1;
    n_ei = 1'b1;
    n_la = 1'b1;
    ea   = 1'b0;
    su   = 1'b0;
    eu   = 1'b0;
    n_lb = 1'b1;
    n_lo = 1'b1;
    if (halted_q) begin
      cp = 1'b0;
    end else begin
      case (ring_q)
        T1: begin
          ep   = 1'b1;
          n_lm = 1'b0;
        end
        T2: begin
          cp = 1'b1;
        end
        T3: begin
          n_ce = 1'b0;
          n_li = 1'b0;
        end
        T4: begin
          case (opcode)
            LDA_OP, ADD_OP, SUB_OP: begin
              n_ei = 1'b0;
              n_lm = 1'b0;
            end
            OUT_OP: begin
              ea   = 1'b1;
              n_lo = 1'b0;
            end
            default: begin
              cp = 1'b0;
            end
          endcase
        end
        T5: begin
          case (opcode)
            LDA_OP: begin
              n_ce = 1'b0;
              n_la = 1'b0;
            end
            ADD_OP: begin
              n_ce = 1'b0;
              n_lb = 1'b0;
            end
            SUB_OP: begin
              n_ce = 1'b0;
              n_lb = 1'b0;
              su   = 1'b1;
            end
            default: begin
              cp = 1'b0;
            end
          endcase
        end
        T6: begin
          case (opcode)
            ADD_OP: begin
              eu   = 1'b1;
              n_la = 1'b0;
            end
            SUB_OP: begin
              eu   = 1'b1;
              n_la = 1'b0;
              su   = 1'b1;
            end
            default: begin
              cp = 1'b0;
            end
          endcase
        end
        default: begin
          cp = 1'b0;
        end
      endcase
    end
  end

  assign t_state = ring_q;
  assign hlt     = halted_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed testbench for controller_sequencer. Strobes are packed as
// {cp,ep,n_lm,n_ce,n_li,n_ei,n_la,ea,su,eu,n_lb,n_lo}.
module tb_controller_sequencer;

  logic       clk;
  logic       clear;
  logic [3:0] opcode;
  logic       cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo;
  logic [5:0] t_state;
  logic       hlt;

  int n_checks;
  int n_fail;

  controller_sequencer dut (
    .clk(clk), .clear(clear), .opcode(opcode),
    .cp(cp), .ep(ep), .n_lm(n_lm), .n_ce(n_ce), .n_li(n_li), .n_ei(n_ei),
    .n_la(n_la), .ea(ea), .su(su), .eu(eu), .n_lb(n_lb), .n_lo(n_lo),
    .t_state(t_state), .hlt(hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written strobe words.
  localparam logic [11:0] IDLE = 12'b0011_1110_0011;
  localparam logic [11:0] F1   = 12'b0101_1110_0011;
  localparam logic [11:0] F2   = 12'b1011_1110_0011;
  localparam logic [11:0] F3   = 12'b0010_0110_0011;
  localparam logic [11:0] LD4  = 12'b0001_1010_0011;
  localparam logic [11:0] LD5  = 12'b0010_1100_0011;
  localparam logic [11:0] AD5  = 12'b0010_1110_0001;
  localparam logic [11:0] AD6  = 12'b0011_1100_0111;
  localparam logic [11:0] SB5  = 12'b0010_1110_1001;
  localparam logic [11:0] SB6  = 12'b0011_1100_1111;
  localparam logic [11:0] OT4  = 12'b0011_1111_0010;

  function automatic logic [11:0] strobes();
    strobes = {cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Run one instruction from T1. Check each of its len states and the return to T1.
  // exp packs six strobe words, with T1 in the low 12 bits.
  task automatic run_instr(input string tag, input logic [3:0] op,
                           input logic [71:0] exp, input int len);
    opcode = op;
    for (int i = 0; i < len; i++) begin
      chk({tag, "_state"}, {26'd0, t_state}, 32'd1 << i);
      chk({tag, "_strobe"}, {20'd0, strobes()}, {20'd0, exp[i*12 +: 12]});
      chk({tag, "_hlt"}, {31'd0, hlt}, 32'd0);
      step();
    end
    chk({tag, "_wrap"}, {26'd0, t_state}, 32'd1);
  endtask

  int len_lda, len_out, len_nop;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    opcode   = 4'h0;
    clear    = 1'b1;
`ifdef SKIP_NOP_EN
    len_lda = 5; len_out = 4; len_nop = 3;
`else
    len_lda = 6; len_out = 6; len_nop = 6;
`endif
    step();
    clear = 1'b0;

    // Reset state.
    chk("rst_state", {26'd0, t_state}, 32'd1);
    chk("rst_strobe", {20'd0, strobes()}, {20'd0, F1});
    chk("rst_hlt", {31'd0, hlt}, 32'd0);

    // Instructions.
    run_instr("lda", 4'h0, {IDLE, LD5, LD4, F3, F2, F1}, len_lda);
    run_instr("add", 4'h1, {AD6, AD5, LD4, F3, F2, F1}, 6);
    run_instr("sub", 4'h2, {SB6, SB5, LD4, F3, F2, F1}, 6);
    run_instr("out", 4'hE, {IDLE, IDLE, OT4, F3, F2, F1}, len_out);
    run_instr("nop7", 4'h7, {IDLE, IDLE, IDLE, F3, F2, F1}, len_nop);

    // HLT: T1-T4 are normal, with hlt still 0 in T4. Then the ring freezes at T5.
    opcode = 4'hF;
    for (int i = 0; i < 4; i++) begin
      chk("hlt_pre_state", {26'd0, t_state}, 32'd1 << i);
      chk("hlt_pre_hlt", {31'd0, hlt}, 32'd0);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      chk("hlt_frozen_state", {26'd0, t_state}, 32'h10);
      chk("hlt_frozen_hlt", {31'd0, hlt}, 32'd1);
      chk("hlt_frozen_strobe", {20'd0, strobes()}, {20'd0, IDLE});
      step();
    end
    chk("hlt_frozen_final", {26'd0, t_state}, 32'h10);
    do_clear();
    chk("hlt_clr_state", {26'd0, t_state}, 32'd1);
    chk("hlt_clr_hlt", {31'd0, hlt}, 32'd0);
    chk("hlt_clr_strobe", {20'd0, strobes()}, {20'd0, F1});

    // Clear during T5 of ADD: the next state is T1 and no T6 n_la pulse occurs.
    opcode = 4'h1;
    for (int i = 0; i < 4; i++) step();
    chk("mid_t5_state", {26'd0, t_state}, 32'h10);
    chk("mid_t5_strobe", {20'd0, strobes()}, {20'd0, AD5});
    do_clear();
    chk("mid_clr_state", {26'd0, t_state}, 32'd1);
    chk("mid_clr_nla", {31'd0, n_la}, 32'd1);
    chk("mid_clr_strobe", {20'd0, strobes()}, {20'd0, F1});

    // After the mid-instruction clear, the ring still completes a full cycle.
    run_instr("add2", 4'h1, {AD6, AD5, LD4, F3, F2, F1}, 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
